apb_mem_slave: RTL and testbench

Parametrised APB3 memory slave: word-addressed RAM of configurable width and depth, with deterministic per-direction wait states, address-range/alignment/write-protect error reporting via `pslverr`, and a two-state access FSM. It is a drop-in APB3 completer on the system bus alongside other APB slaves and replaces fixed 64-word RAM slaves where depth, timing or error behaviour must be controlled.

---
 rtl/apb_mem_slave.sv | 106 ++++++++++
 tb/tb_apb_mem_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB3 word-addressed RAM completer with fixed per-direction wait states and pslverr on range/alignment/protect faults.
// Latency: 1 setup + (WAIT+1) access cycles; waits are the only backpressure, and dropping psel in ACCESS aborts the transfer.
module apb_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  wprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [MW-1:0] idx;
        logic          wr;
        logic          err;
    } req_t;

    state_t                state_q, state_d;
    req_t                  req_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  setup;
    logic                  in_range;
    logic                  req_err;
    logic                  access_beat;
    logic                  done;
    logic [IW-1:0]         word_idx;
    logic [MW-1:0]         mem_idx;

    // The full upper address is range-checked so out-of-range indices never alias onto real words.
    assign word_idx    = paddr[ADDR_WIDTH-1:2];
    assign mem_idx     = paddr[MW+1:2];
    assign in_range    = word_idx < IW'(DEPTH);
    assign req_err     = ~in_range | (paddr[1:0] != 2'b00) | (pwrite & wprot);
    assign setup       = psel & ~penable;
    assign access_beat = (state_q == ACCESS) & psel & penable;
    assign done        = access_beat & (cnt_q == 4'd0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                req_q   <= '{idx: mem_idx, wr: pwrite, err: req_err};
                cnt_q   <= pwrite ? 4'(WR_WAIT) : 4'(RD_WAIT);
                rdata_q <= in_range ? mem[mem_idx] : '0;
            end else if (access_beat && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (setup) begin
            state_d = ACCESS;
        end else if (state_q == ACCESS) begin
            if (!psel || done) begin
                state_d = IDLE;
            end
        end
        if (done) begin
            pready  = 1'b1;
            pslverr = req_q.err;
            if (!req_q.wr && !req_q.err) begin
                prdata = rdata_q;
            end
        end
    end

    // Storage is deliberately not reset; done is held low by the async-reset state register.
    always_ff @(posedge pclk) begin
        if (done && req_q.wr && !req_q.err) begin
            mem[req_q.idx] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (DEPTH 48 / RD1 WR0, and DEPTH 64 / RD3 WR2) checked against a word-array model.
// Expected error, latency and read data are derived from the address rules, not from the design's internal state.
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        presetn [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic        wprot   [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] mdl [2][64];
    bit          vld [2][64];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 pclk = ~pclk;

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(48), .RD_WAIT(1), .WR_WAIT(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .wprot(wprot[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .RD_WAIT(3), .WR_WAIT(2)) u_dut1 (
        .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .wprot(wprot[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1])
    );

    function automatic int dep(input int d);
        return (d == 0) ? 48 : 64;
    endfunction

    function automatic int rdw(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int wrw(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int d, input int n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Entered and left at posedge+1, leaving psel high so a following transfer runs back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit prot, output logic [31:0] rd, output bit err, output int waits);
        bit got;
        int n;
        got   = 1'b0;
        n     = 0;
        waits = 0;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wd;
        wprot[d]   = prot;
        @(negedge pclk);
        chk("setup_pready", 32'(pready[d]), 32'd0);
        @(posedge pclk);
        #1;
        penable[d] = 1'b1;
        paddr[d]   = $urandom;
        pwrite[d]  = ~wr;
        pwrite[d]  = wr;
        while (!got && n < 40) begin
            @(negedge pclk);
            if (pready[d]) begin
                got = 1'b1;
            end else begin
                waits++;
                chk("wait_prdata", prdata[d], 32'd0);
                chk("wait_pslverr", 32'(pslverr[d]), 32'd0);
                @(posedge pclk);
                #1;
            end
            n++;
        end
        if (!got) chk("pready_timeout", 32'(pready[d]), 32'd1);
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge pclk);
        #1;
    endtask

    task automatic op(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input bit prot, input string tag);
        logic [31:0] rd;
        bit          err;
        bit          exp_err;
        int          waits;
        longint      idx;
        idx     = longint'(addr >> 2);
        exp_err = (idx >= dep(d)) || (addr[1:0] != 2'b00) || (wr && prot);
        xfer(d, wr, addr, wd, prot, rd, err, waits);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_wait"}, 32'(waits), 32'(wr ? wrw(d) : rdw(d)));
        if (wr || exp_err) begin
            chk({tag, "_rd0"}, rd, 32'd0);
        end else if (vld[d][idx]) begin
            chk({tag, "_rd"}, rd, mdl[d][idx]);
        end
        if (wr && !exp_err) begin
            mdl[d][idx] = wd;
            vld[d][idx] = 1'b1;
        end
    endtask

    task automatic rand_ops(input int d, input int count);
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'($urandom_range(0, dep(d) - 1) * 4 + $urandom_range(1, 3));
            else if (r == 1) addr = 32'((dep(d) + $urandom_range(0, 20)) * 4);
            else if (r == 2) addr = 32'h8000_0000 | 32'($urandom_range(0, 3) * 4);
            else             addr = 32'($urandom_range(0, dep(d) - 1) * 4);
            op(d, 1'($urandom_range(0, 1)), addr, $urandom, ($urandom_range(0, 7) == 0), "rnd");
            if ($urandom_range(0, 3) == 0) idle(d, 1);
        end
        idle(d, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        int          n;
        for (int d = 0; d < 2; d++) begin
            presetn[d] = 1'b1;
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            pwrite[d]  = 1'b0;
            wprot[d]   = 1'b0;
            paddr[d]   = '0;
            pwdata[d]  = '0;
        end
        #1;
        presetn[0] = 1'b0;
        presetn[1] = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("rst_pready", 32'(pready[d]), 32'd0);
            chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
            chk("rst_prdata", prdata[d], 32'd0);
        end
        repeat (2) @(posedge pclk);
        #1;
        presetn[0] = 1'b1;
        presetn[1] = 1'b1;
        idle(0, 1);

        // Instance 0: basic access, range, alignment and write-protect.
        op(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
        op(0, 1'b0, 32'h10, 32'h0, 1'b0, "rd10");
        op(0, 1'b1, 32'h00, 32'h0BADF00D, 1'b0, "wr0");
        op(0, 1'b1, 32'hC0, 32'h12345678, 1'b0, "wr_oor");
        op(0, 1'b0, 32'hC0, 32'h0, 1'b0, "rd_oor");
        op(0, 1'b0, 32'h00, 32'h0, 1'b0, "rd0");
        op(0, 1'b1, 32'hBC, 32'hCAFEF00D, 1'b0, "wr47");
        op(0, 1'b0, 32'hBC, 32'h0, 1'b0, "rd47");
        op(0, 1'b0, 32'h11, 32'h0, 1'b0, "rd_mis");
        op(0, 1'b1, 32'h20, 32'h11112222, 1'b0, "wr20");
        op(0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, "wr_prot");
        op(0, 1'b0, 32'h20, 32'h0, 1'b0, "rd20");
        idle(0, 2);

        // Instance 1: wait sweep.
        op(1, 1'b1, 32'h08, 32'h5A5A0001, 1'b0, "wr8");
        op(1, 1'b0, 32'h08, 32'h0, 1'b0, "rd8");
        idle(1, 1);

        // Abort a write by dropping psel in its second wait cycle.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h08; pwdata[1] = 32'hFFFF0000; wprot[1] = 1'b0;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(negedge pclk);
        chk("abort_w1", 32'(pready[1]), 32'd0);
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge pclk);
        chk("abort_w2", 32'(pready[1]), 32'd0);
        @(posedge pclk); #1;
        // Access phase without a setup must be ignored.
        psel[1] = 1'b1; penable[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("orphan_pready", 32'(pready[1]), 32'd0);
            @(posedge pclk); #1;
        end
        idle(1, 1);
        op(1, 1'b0, 32'h08, 32'h0, 1'b0, "rd_after_abort");

        // Reset during the completion cycle of a read.
        op(1, 1'b1, 32'h30, 32'h600DCAFE, 1'b0, "wr30");
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h30; wprot[1] = 1'b0;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        n = 0;
        @(negedge pclk);
        while (!pready[1] && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("rst_mid_pre_pready", 32'(pready[1]), 32'd1);
        chk("rst_mid_pre_prdata", prdata[1], 32'h600DCAFE);
        #1;
        presetn[1] = 1'b0;
        #1;
        chk("rst_mid_pready", 32'(pready[1]), 32'd0);
        chk("rst_mid_pslverr", 32'(pslverr[1]), 32'd0);
        chk("rst_mid_prdata", prdata[1], 32'd0);
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        presetn[1] = 1'b1;
        idle(1, 1);
        op(1, 1'b0, 32'h30, 32'h0, 1'b0, "rd_after_rst");
        op(1, 1'b1, 32'h34, 32'h0F0F0F0F, 1'b0, "wr_after_rst");
        op(1, 1'b0, 32'h34, 32'h0, 1'b0, "rd34");

        // Back-to-back write/read pairs, no idle cycles.
        for (int i = 0; i < 64; i++) begin
            op(1, 1'b1, 32'(i * 4), $urandom, 1'b0, "b2b_wr");
            op(1, 1'b0, 32'(i * 4), 32'h0, 1'b0, "b2b_rd");
        end
        idle(1, 1);

        rand_ops(0, 150);
        rand_ops(1, 150);

        old = mdl[0][0];
        op(0, 1'b0, 32'h00, 32'h0, 1'b0, "final_rd0");
        chk("final_mdl0", prdata[0], 32'd0);
        if (old !== mdl[0][0]) chk("mdl_stable", mdl[0][0], old);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
